// File: rtl/noc_input_port.sv
// noc_input_port
//   Receive side of one router link. Incoming flits are buffered in a
//   DEPTH-entry show-ahead FIFO. The head flit is presented to the local
//   switch allocator together with its XY-routing label, and it is popped
//   when the allocator asserts ready.
//
//   Flit layout: src[39:36] dst[35:32] timestamp[31:24] data[23:2] type[1:0]
//   Label codes: 0 none, 1 local, 2 north, 3 east, 4 south, 5 west
//
// Ports
//   clk         clock; all state changes on the rising edge
//   rst         synchronous reset, active-high
//   data_valid  upstream flit present this cycle
//   data_in     upstream flit
//   full        FIFO full; upstream must not send while high
//   ready       allocator consumed the head flit this cycle
//   data_out    head flit, or 0 when empty
//   label       route request for the head flit, or 0 when empty
//   count       occupancy, 0..DEPTH
//   ovf         sticky flag: a write was attempted while full
module noc_input_port #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned MY_X     = 0,
  parameter int unsigned MY_Y     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_valid,
  input  logic [DATASIZE-1:0] data_in,
  output logic                full,
  input  logic                ready,
  output logic [DATASIZE-1:0] data_out,
  output logic [3:0]          label,
  output logic [WIDTH:0]      count,
  output logic                ovf
);

  localparam logic [1:0] C_MY_X = 2'(MY_X);
  localparam logic [1:0] C_MY_Y = 2'(MY_Y);

  localparam logic [3:0] C_LBL_NONE  = 4'd0;
  localparam logic [3:0] C_LBL_LOCAL = 4'd1;
  localparam logic [3:0] C_LBL_NORTH = 4'd2;
  localparam logic [3:0] C_LBL_EAST  = 4'd3;
  localparam logic [3:0] C_LBL_SOUTH = 4'd4;
  localparam logic [3:0] C_LBL_WEST  = 4'd5;

  logic [DATASIZE-1:0] r_mem [DEPTH];
  logic [WIDTH:0]      r_wr_ptr;
  logic [WIDTH:0]      r_rd_ptr;
  logic                r_ovf;

  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [DATASIZE-1:0] w_head;
  logic [1:0]          w_dx;
  logic [1:0]          w_dy;

  // Pointers carry one extra wrap bit, so full and empty are told apart
  // without a separate occupancy register.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[WIDTH-1:0] == r_rd_ptr[WIDTH-1:0]) &&
                   (r_wr_ptr[WIDTH] != r_rd_ptr[WIDTH]);

  // full is taken from the registered pointers, so a push that arrives
  // while full is dropped even when a pop happens in the same cycle.
  assign w_push = data_valid && !w_full;
  assign w_pop  = ready && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (data_valid && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // The storage array has no reset. Entries are only read when the
  // pointers mark them valid, and an empty FIFO drives data_out to 0.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr[WIDTH-1:0]] <= data_in;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[WIDTH-1:0]];
  assign w_dx   = w_head[35:34];
  assign w_dy   = w_head[33:32];

  // XY routing: resolve the column first, then the row.
  always_comb begin
    label = C_LBL_NONE;
    if (!w_empty) begin
      if (w_dx > C_MY_X) begin
        label = C_LBL_EAST;
      end else if (w_dx < C_MY_X) begin
        label = C_LBL_WEST;
      end else if (w_dy > C_MY_Y) begin
        label = C_LBL_SOUTH;
      end else if (w_dy < C_MY_Y) begin
        label = C_LBL_NORTH;
      end else begin
        label = C_LBL_LOCAL;
      end
    end
  end

  assign data_out = w_head;
  assign full     = w_full;
  assign count    = r_wr_ptr - r_rd_ptr;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_noc_input_port.sv
module tb_noc_input_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [39:0] data_in = '0;
  logic        ready = 1'b0;

  logic        full_a, ovf_a, full_b, ovf_b;
  logic [39:0] data_out_a, data_out_b;
  logic [3:0]  label_a, label_b;
  logic [3:0]  count_a, count_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [39:0] mdl_q[$];
  bit          mdl_ovf = 1'b0;

  always #5 clk = ~clk;

  noc_input_port #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .MY_X(0), .MY_Y(0)) u_dut_a (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .full(full_a), .ready(ready), .data_out(data_out_a), .label(label_a),
    .count(count_a), .ovf(ovf_a)
  );

  noc_input_port #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .MY_X(1), .MY_Y(1)) u_dut_b (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .full(full_b), .ready(ready), .data_out(data_out_b), .label(label_b),
    .count(count_b), .ovf(ovf_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] route(input logic [39:0] f, input int mx, input int my);
    int dx, dy;
    dx = int'(f[35:34]);
    dy = int'(f[33:32]);
    if (dx > mx) return 4'd3;
    if (dx < mx) return 4'd5;
    if (dy > my) return 4'd4;
    if (dy < my) return 4'd2;
    return 4'd1;
  endfunction

  function automatic logic [39:0] mk(input logic [3:0] dst, input int idx);
    return {4'hA, dst, 8'(idx), 22'(idx * 37 + 5), 2'b10};
  endfunction

  // Reference FIFO: a queue with a depth limit evaluated before the edge.
  always @(posedge clk) begin
    if (rst) begin
      mdl_q.delete();
      mdl_ovf = 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (mdl_q.size() == 8);
      was_empty = (mdl_q.size() == 0);
      if (ready && !was_empty) void'(mdl_q.pop_front());
      if (data_valid && !was_full) mdl_q.push_back(data_in);
      else if (data_valid && was_full) mdl_ovf = 1'b1;
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [39:0] head;
      logic [3:0]  la, lb;
      int          sz;
      sz   = mdl_q.size();
      head = (sz == 0) ? 40'd0 : mdl_q[0];
      la   = (sz == 0) ? 4'd0 : route(head, 0, 0);
      lb   = (sz == 0) ? 4'd0 : route(head, 1, 1);
      chk("a.count", 64'(count_a), 64'(sz));
      chk("a.full", 64'(full_a), 64'(sz == 8));
      chk("a.ovf", 64'(ovf_a), 64'(mdl_ovf));
      chk("a.data_out", 64'(data_out_a), 64'(head));
      chk("a.label", 64'(label_a), 64'(la));
      chk("b.count", 64'(count_b), 64'(sz));
      chk("b.full", 64'(full_b), 64'(sz == 8));
      chk("b.ovf", 64'(ovf_b), 64'(mdl_ovf));
      chk("b.data_out", 64'(data_out_b), 64'(head));
      chk("b.label", 64'(label_b), 64'(lb));
    end
  end

  task automatic step(input logic v, input logic [39:0] d, input logic r);
    data_valid = v;
    data_in    = d;
    ready      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 40'hFF_FFFF_FFFF, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  rt_dst [5];
    logic [3:0]  rt_lbl [5];
    logic [39:0] f;

    rt_dst = '{4'b1001, 4'b0001, 4'b0110, 4'b0100, 4'b0101};
    rt_lbl = '{4'd3, 4'd5, 4'd4, 4'd2, 4'd1};

    step(1'b0, '0, 1'b0);
    do_reset();
    chk("rst.count", 64'(count_a), 64'd0);
    chk("rst.full", 64'(full_a), 64'd0);
    chk("rst.label", 64'(label_a), 64'd0);
    chk("rst.data_out", 64'(data_out_a), 64'd0);

    // single flit with local destination at router (0,0)
    f = mk(4'b0000, 1);
    step(1'b1, f, 1'b0);
    chk("single.label", 64'(label_a), 64'd1);
    chk("single.count", 64'(count_a), 64'd1);
    chk("single.data_out", 64'(data_out_a), 64'(f));
    step(1'b0, '0, 1'b1);
    chk("single.pop_label", 64'(label_a), 64'd0);
    chk("single.pop_count", 64'(count_a), 64'd0);
    step(1'b0, '0, 1'b1);
    chk("empty_pop.count", 64'(count_a), 64'd0);

    // XY routing at router (1,1)
    for (int i = 0; i < 5; i++) step(1'b1, mk(rt_dst[i], 10 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("route.label", 64'(label_b), 64'(rt_lbl[i]));
      step(1'b0, '0, 1'b1);
    end

    // fill, overflow, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, mk(4'(i), 20 + i), 1'b0);
    chk("fill.full", 64'(full_a), 64'd1);
    chk("fill.count", 64'(count_a), 64'd8);
    step(1'b1, mk(4'hF, 99), 1'b0);
    chk("fill.ovf", 64'(ovf_a), 64'd1);
    chk("fill.count9", 64'(count_a), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("fill.order", 64'(data_out_a), 64'(mk(4'(i), 20 + i)));
      step(1'b0, '0, 1'b1);
    end
    chk("fill.drained", 64'(count_a), 64'd0);

    // streaming with push and pop every cycle across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step(1'b1, mk(4'(i % 16), 40 + i), 1'b1);
      chk("wrap.count", 64'(count_a), 64'd1);
      chk("wrap.full", 64'(full_a), 64'd0);
      chk("wrap.head", 64'(data_out_a), 64'(mk(4'(i % 16), 40 + i)));
    end
    step(1'b0, '0, 1'b1);

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, mk(4'(15 - i), 70 + i), 1'b0);
    chk("fullsim.pre_ovf", 64'(ovf_a), 64'd0);
    step(1'b1, mk(4'h3, 98), 1'b1);
    chk("fullsim.count", 64'(count_a), 64'd7);
    chk("fullsim.ovf", 64'(ovf_a), 64'd1);
    chk("fullsim.head", 64'(data_out_a), 64'(mk(4'd14, 71)));

    // mid-operation reset
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("midrst.pre_count", 64'(count_a), 64'd5);
    do_reset();
    chk("midrst.count", 64'(count_a), 64'd0);
    chk("midrst.full", 64'(full_a), 64'd0);
    chk("midrst.ovf", 64'(ovf_a), 64'd0);
    chk("midrst.label", 64'(label_a), 64'd0);
    chk("midrst.data_out", 64'(data_out_a), 64'd0);
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
